// File: rtl/i2c_slave_if.sv
// Pad-side I2C signals between a bus master model and the i2c_slave target.
// SDA is open-drain: the target only asserts sda_oe to pull the line low.
interface i2c_slave_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a 16 x 8 register file, auto-incrementing pointer and
// open-drain SDA; the bus is oversampled by the 100 MHz system clock.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic        clk100mhz,
  input  logic        res,
  i2c_slave_if.slave  bus,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  input  logic [3:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  // [0] first sync stage, [1] synchronized level, [2] previous level
  logic [2:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic       start_q, start_d, stop_q, stop_d;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [3:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regfile_q [16];
  logic [7:0] regfile_d [16];
  logic [7:0] rx_byte, rd_byte;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], bus.scl_in};
    sda_sync_d = {sda_sync_q[1:0], bus.sda_in};
    scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
    scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
    start_d    = sda_sync_q[2] & ~sda_sync_q[1] & scl_sync_q[1];
    stop_d     = ~sda_sync_q[2] & sda_sync_q[1] & scl_sync_q[1];
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regfile_d   = regfile_q;
    rx_byte     = {shift_q[6:0], sda_sync_q[1]};
    rd_byte     = regfile_q[ptr_q];

    if (stop_q) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_q) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise_q) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == S_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = S_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_REG) begin
                ptr_d   = rx_byte[3:0];
                state_d = S_REG_ACK;
              end else begin
                regfile_d[ptr_q] = rx_byte;
                wr_strobe_d      = 1'b1;
                wr_addr_d        = ptr_q;
                wr_data_d        = rx_byte;
                ptr_d            = ptr_q + 4'd1;
                state_d          = S_WDATA_ACK;
              end
            end
          end
        end
        // sda_oe_q marks the ACK phase: set on the first fall, cleared on the second.
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall_q) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d  = S_RDATA;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_REG;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        // bit_cnt_q == 8 means a byte load is pending after the master's ACK.
        S_RDATA: begin
          if (scl_fall_q) begin
            if (bit_cnt_q == 4'd8) begin
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = '0;
            end else if (bit_cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 4'd1;
              state_d  = S_RDATA_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise_q) begin
            if (!sda_sync_q[1]) begin
              state_d   = S_RDATA;
              bit_cnt_d = 4'd8;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk100mhz) begin
    if (res) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_rise_q  <= 1'b0;
      scl_fall_q  <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < 16; i++) regfile_q[i] <= '0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_rise_q  <= scl_rise_d;
      scl_fall_q  <= scl_fall_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regfile_q   <= regfile_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign dbg_data   = regfile_q[dbg_addr];

endmodule
